// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - four-channel 8-bit LED PWM with double-buffered duties and register port
// Pads are active-low; duties written by software take effect only at the count 255->0 wrap.
module led_pwm #(
    parameter int unsigned PRESCALE = 47
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [2:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        LED,
    output logic        RGB_R,
    output logic        RGB_G,
    output logic        RGB_B
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [3:0][7:0] pend_q, pend_d;
    logic [3:0][7:0] act_q, act_d;
    logic [15:0]     pre_q, pre_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            en_q, en_d;
    logic            wrap_flag_q, wrap_flag_d;
    logic [3:0]      pad_q, pad_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic [31:0]     rd_val;
    logic            tick;
    logic            wrap;

    always_comb begin
        tick = en_q && (pre_q == PRE_MAX);
        wrap = tick && (cnt_q == 8'hFF);

        pend_d = pend_q;
        if (wr_en && !addr[2]) begin
            pend_d[addr[1:0]] = wr_data[7:0];
        end

        en_d = en_q;
        if (wr_en && (addr == 3'd4)) begin
            en_d = wr_data[0];
        end

        pre_d = (!en_q || tick) ? 16'd0 : pre_q + 16'd1;

        if (!en_q) begin
            cnt_d = 8'd0;
        end else if (tick) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // Active copies see the pre-write pending values, so a write on the wrap edge waits a period.
        act_d = (!en_q || wrap) ? pend_q : act_q;

        if (wrap) begin
            wrap_flag_d = 1'b1;
        end else if (wr_en && (addr == 3'd5) && wr_data[16]) begin
            wrap_flag_d = 1'b0;
        end else begin
            wrap_flag_d = wrap_flag_q;
        end

        for (int i = 0; i < 4; i++) begin
            pad_d[i] = !(en_q && (cnt_q < act_q[i]));
        end

        case (addr)
            3'd0, 3'd1, 3'd2, 3'd3: rd_val = {24'd0, pend_q[addr[1:0]]};
            3'd4:                   rd_val = {31'd0, en_q};
            3'd5:                   rd_val = {15'd0, wrap_flag_q, cnt_q, 7'd0, en_q};
            default:                rd_val = 32'd0;
        endcase

        rd_data_d = rd_en ? rd_val : rd_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q      <= '0;
            act_q       <= '0;
            pre_q       <= 16'd0;
            cnt_q       <= 8'd0;
            en_q        <= 1'b0;
            wrap_flag_q <= 1'b0;
            pad_q       <= 4'hF;
            rd_data_q   <= 32'd0;
        end else begin
            pend_q      <= pend_d;
            act_q       <= act_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            wrap_flag_q <= wrap_flag_d;
            pad_q       <= pad_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign LED     = pad_q[0];
    assign RGB_R   = pad_q[1];
    assign RGB_G   = pad_q[2];
    assign RGB_B   = pad_q[3];

endmodule

// File: tb/tb_led_pwm.sv
// tb/tb_led_pwm.sv - directed self-checking bench for led_pwm with PRESCALE=2 (512-clk period)
module tb_led_pwm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic        LED, RGB_R, RGB_G, RGB_B;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0 = 0;
    int lows[4];
    int base[4];
    logic [31:0] v;

    always #5 clk = ~clk;

    led_pwm #(.PRESCALE(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .LED     (LED),
        .RGB_R   (RGB_R),
        .RGB_G   (RGB_G),
        .RGB_B   (RGB_B)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Low-time accumulators, sampled on the falling edge.
    always @(negedge clk) begin
        if (!LED)   lows[0] = lows[0] + 1;
        if (!RGB_R) lows[1] = lows[1] + 1;
        if (!RGB_G) lows[2] = lows[2] + 1;
        if (!RGB_B) lows[3] = lows[3] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1; addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b1; addr = a; wr_data = wd;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        d = rd_data;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
        check("align", 32'(cyc), 32'(t));
    endtask

    task automatic mark();
        for (int i = 0; i < 4; i++) base[i] = lows[i];
    endtask

    task automatic win_check(input string tag, input int e_led, input int e_r, input int e_g, input int e_b);
        check({tag, "_led"}, 32'(lows[0] - base[0]), 32'(e_led));
        check({tag, "_r"},   32'(lows[1] - base[1]), 32'(e_r));
        check({tag, "_g"},   32'(lows[2] - base[2]), 32'(e_g));
        check({tag, "_b"},   32'(lows[3] - base[3]), 32'(e_b));
        mark();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin lows[i] = 0; base[i] = 0; end
        repeat (3) @(negedge clk);
        #1;
        check("rst_pads", {28'd0, RGB_B, RGB_G, RGB_R, LED}, 32'hF);
        check("rst_rd_data", rd_data, 32'd0);
        reset = 1'b1;

        rd(3'd0, v); check("rst_duty_led", v, 32'd0);
        rd(3'd5, v); check("rst_status", v, 32'd0);

        wr(3'd0, 32'hFFFF_FF12);
        rd(3'd0, v); check("duty_upper_masked", v, 32'h12);
        wr(3'd0, 32'd0);
        wr(3'd6, 32'hDEAD_BEEF);
        rd(3'd6, v); check("addr6_zero", v, 32'd0);
        rd(3'd7, v); check("addr7_zero", v, 32'd0);
        check("disabled_pads", {28'd0, RGB_B, RGB_G, RGB_R, LED}, 32'hF);

        wr(3'd1, 32'h11);
        rw(3'd1, 32'd64, v); check("rw_prewrite", v, 32'h11);
        rd(3'd1, v); check("duty_r_after_rw", v, 32'd64);
        repeat (3) @(posedge clk);
        #1;
        check("rd_hold", rd_data, 32'd64);

        wr(3'd4, 32'hFFFF_FFFF);
        c0 = cyc;

        wait_cyc(c0 + 74);
        rd(3'd5, v); check("status_cnt37", v, 32'h0000_2501);
        rd(3'd4, v); check("ctrl_read", v, 32'd1);

        wait_cyc(c0 + 513);
        mark();
        wait_cyc(c0 + 530);
        rd(3'd5, v); check("wrap_flag_set", {31'd0, v[16]}, 32'd1);
        wait_cyc(c0 + 1025);
        win_check("w1", 0, 128, 0, 0);

        wait_cyc(c0 + 1100);
        wr(3'd5, 32'h0001_0000);
        rd(3'd5, v); check("wrap_flag_clr", {31'd0, v[16]}, 32'd0);
        wait_cyc(c0 + 1535);
        wr(3'd5, 32'h0001_0000);
        rd(3'd5, v); check("wrap_set_wins", {31'd0, v[16]}, 32'd1);

        wait_cyc(c0 + 1600);
        wr(3'd2, 32'd200);
        wait_cyc(c0 + 2049);
        mark();
        wait_cyc(c0 + 2149);
        wr(3'd2, 32'd10);
        wait_cyc(c0 + 2561);
        win_check("w2", 0, 128, 400, 0);

        wait_cyc(c0 + 3071);
        wr(3'd3, 32'd255);
        wait_cyc(c0 + 3073);
        win_check("w3", 0, 128, 20, 0);
        wait_cyc(c0 + 3585);
        win_check("w4", 0, 128, 20, 0);
        wait_cyc(c0 + 3600);
        wr(3'd0, 32'd255);
        wait_cyc(c0 + 4097);
        win_check("w5", 0, 128, 20, 510);

        wait_cyc(c0 + 4296);
        check("led_lit_cnt100", {31'd0, LED}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pads", {28'd0, RGB_B, RGB_G, RGB_R, LED}, 32'hF);
        check("async_rst_rd_data", rd_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd(3'd4, v); check("post_rst_ctrl", v, 32'd0);
        rd(3'd0, v); check("post_rst_duty_led", v, 32'd0);
        mark();
        repeat (600) @(posedge clk);
        #1;
        win_check("post_rst", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 Parameter: PRESCALE, 47, clk cycles per PWM count step; legal range 1..65535; 12 MHz / (47*256) gives a period of about 1 kHz.
REQ-002 Port: clk  input  1  system clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: wr_en  input  1  register write strobe, sampled on rising clk.
REQ-005 Port: rd_en  input  1  register read strobe, sampled on rising clk.
REQ-006 Port: addr  input  3  word register address (0..7).
REQ-007 Port: wr_data  input  32  write data.
REQ-008 Port: rd_data  output  32  registered read data.
REQ-009 Ports: LED, RGB_R, RGB_G, RGB_B  output  1 each  PWM pad drives, active-low (0 = lit).

Function
REQ-010 Register map SHALL be as follows.
- 0 = DUTY_LED, 1 = DUTY_R, 2 = DUTY_G, 3 = DUTY_B: bits[7:0] pending duty; upper bits ignored on write and read as 0.
- 4 = CTRL: bit0 enable; all other bits read 0.
- 5 = STATUS: bit0 = enable (read-only), bits[15:8] = current PWM count, bit16 = wrap flag (sticky, write-1-to-clear).
- 6, 7: writes ignored, reads return 0.
REQ-011 Each channel SHALL hold a pending duty and an active duty; register writes modify only the pending duty.
REQ-012 Prescaler SHALL count 0..PRESCALE-1 while enabled; the cycle where it equals PRESCALE-1 is a tick, and the prescaler returns to 0 on the next cycle.
REQ-013 The 8-bit PWM count SHALL advance by 1 on each tick and wrap from 255 to 0.
REQ-014 A wrap SHALL be the tick at which the count is 255; on that edge all four active duties SHALL load their pending values together.
REQ-015 A duty write on the same edge as a wrap SHALL update pending only; active SHALL take the pre-write pending value, and the new value applies at the next wrap.
REQ-016 Each channel output SHALL be lit when count < active duty; duty 0 is never lit, and duty 255 is lit 255 of 256 counts.
REQ-017 Pad outputs SHALL be registered, so a pad changes one clk after the count or active duty changes.
REQ-018 While enable=0:
- the prescaler and count are held at 0;
- all pads are driven 1 (off);
- active duties follow pending duties every cycle.
REQ-019 Writing enable 0->1 SHALL start the first tick PRESCALE cycles later, with the count beginning at 0.
REQ-020 Writing enable 1->0 SHALL clear the prescaler and count on the next edge, with pads reading 1 one cycle after that.
REQ-021 Wrap flag SHALL set on every wrap; a STATUS write with bit16=1 SHALL clear it; a set and clear on the same edge SHALL leave the flag set.
REQ-022 A read with rd_en=1 SHALL present the register value sampled at that edge on rd_data one cycle later; rd_data SHALL hold its value when rd_en=0.
REQ-023 A read and a write to the same address on the same edge SHALL return the pre-write value.
REQ-024 When PRESCALE=1, every enabled cycle SHALL be a tick.

Reset
REQ-025 Asserting reset (low) SHALL asynchronously clear:
- all pending and active duties, enable, the prescaler, the count, the wrap flag and rd_data to 0;
- all pads to 1.
REQ-026 Reset asserted mid-period SHALL abandon the period; after release the block SHALL stay idle (disabled) until CTRL is written.
REQ-027 Reset release SHALL take effect on the first rising clk at which reset is sampled high.

Verification
REQ-028 PRESCALE=2; write DUTY_R=64 then CTRL=1 -> after the first wrap, RGB_R is low for 128 clk and high for 384 clk per 512-clk period; LED, RGB_G and RGB_B stay high.
REQ-029 Enabled, DUTY_G=200; write DUTY_G=10 mid-period -> the current period keeps 200-count low time, and the next period shows 10.
REQ-030 Write DUTY_B=255 on the exact wrap edge, previous pending 0 -> the following period shows RGB_B never lit; the period after that shows it lit for counts 0..254.
REQ-031 Wrap occurs, then STATUS is written with bit16=1 on the next wrap edge -> a STATUS read returns bit16=1; clearing on a non-wrap edge -> the read returns 0.
REQ-032 Pull reset low at count 100 with DUTY_LED=255 -> LED goes high immediately; a CTRL read returns 0 and a DUTY_LED read returns 0; after release the pads stay high.
REQ-033 Issue rd_en with addr=5 while count=37 and enabled -> rd_data one cycle later equals 0x0000_2501 (bit16=0, count=37, enable=1).
